// File: rtl/multicycle_ctrl_if.sv
// Control/strobe bundle between the multi-cycle RV32I control FSM (master) and the
// datapath side that supplies instruction fields and memory handshake (slave).
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero;
  logic       mem_ready;
  logic       trap_ack;
  logic       mem_req;
  logic       mem_we;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] ALUOp;
  logic       alu_f7_valid;
  logic [1:0] result_src;
  logic       instr_done;
  logic       trap;
  logic [1:0] trap_cause;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, alu_zero, mem_ready, trap_ack,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, ALUOp, alu_f7_valid, result_src,
           instr_done, trap, trap_cause, state
  );

  modport slave (
    output opcode, funct3, alu_zero, mem_ready, trap_ack,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, ALUOp, alu_f7_valid, result_src,
           instr_done, trap, trap_cause, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/execute/mem/writeback
// sequencing, datapath strobes, illegal-opcode and memory-timeout traps.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  localparam int               CNT_W      = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic             TIMEOUT_EN = (MEM_TIMEOUT != 0);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_LUI    = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  // Strobes that depend on mem_ready/alu_zero are kept as enables here and gated at the outputs.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       fetch;
    logic       jal;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       f7_valid;
    logic [1:0] result_src;
    logic       done;
    logic       done_on_ready;
    logic       trap;
  } ctl_t;

  function automatic ctl_t decode_ctl(input state_e s, input logic f3_is_shift_right);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.fetch      = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req       = 1'b1;
        c.mem_we        = 1'b1;
        c.i_or_d        = 1'b1;
        c.done_on_ready = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b10;
        c.f7_valid  = 1'b1;
      end
      // Only SRLI/SRAI carry a meaningful funct7; ADDI must not look like SUB.
      S_EXEC_I: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
        c.f7_valid  = f3_is_shift_right;
      end
      S_ALUWB: begin
        c.result_src = 2'b00;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
        c.done      = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b10;
        c.jal       = 1'b1;
      end
      S_LUI: begin
        c.result_src = 2'b11;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      S_TRAP:  c.trap = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  ctl_t             ctl_q, ctl_d;
  logic             wait_st;
  logic             expired;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    expired = TIMEOUT_EN && wait_st && !bus.mem_ready && (cnt_q == CNT_LAST);

    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          OP_BRANCH: begin
            if (bus.funct3 == 3'b000 || bus.funct3 == 3'b001) begin
              state_d = S_BRANCH;
            end else begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      S_LUI:    state_d = S_FETCH;
      S_TRAP: begin
        if (bus.trap_ack) begin
          state_d = S_FETCH;
          cause_d = CAUSE_NONE;
        end
      end
      default:  state_d = S_FETCH;
    endcase

    // A late mem_ready in the final allowed cycle beats the timeout.
    if (expired) begin
      state_d = S_TRAP;
      cause_d = CAUSE_BUS;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_st && !bus.mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    ctl_d = decode_ctl(state_d, bus.funct3 == 3'b101);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
      ctl_q   <= decode_ctl(S_FETCH, 1'b0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      ctl_q   <= ctl_d;
    end
  end

  assign bus.mem_req      = ctl_q.mem_req;
  assign bus.mem_we       = ctl_q.mem_we;
  assign bus.i_or_d       = ctl_q.i_or_d;
  assign bus.ir_write     = ctl_q.fetch & bus.mem_ready;
  // BRANCH is only entered for BEQ (funct3 000) or BNE (001), so funct3[0] selects polarity.
  assign bus.pc_write     = (ctl_q.fetch & bus.mem_ready) | ctl_q.jal |
                            (ctl_q.branch & (bus.funct3[0] ^ bus.alu_zero));
  assign bus.reg_write    = ctl_q.reg_write;
  assign bus.alu_src_a    = ctl_q.alu_src_a;
  assign bus.alu_src_b    = ctl_q.alu_src_b;
  assign bus.ALUOp        = ctl_q.alu_op;
  assign bus.alu_f7_valid = ctl_q.f7_valid;
  assign bus.result_src   = ctl_q.result_src;
  assign bus.instr_done   = ctl_q.done | (ctl_q.done_on_ready & bus.mem_ready);
  assign bus.trap         = ctl_q.trap;
  assign bus.trap_cause   = cause_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction phase sequences are expanded from
// the cycle-count rules and every cycle's outputs are compared against the state table.
module tb_multicycle_ctrl;

  localparam logic [3:0] P_FETCH = 4'd0, P_DECODE = 4'd1, P_MEMADR = 4'd2, P_MEMRD = 4'd3,
                         P_MEMWB = 4'd4, P_MEMWR = 4'd5, P_EXEC_R = 4'd6, P_EXEC_I = 4'd7,
                         P_ALUWB = 4'd8, P_BRANCH = 4'd9, P_JAL = 4'd10, P_LUI = 4'd11,
                         P_TRAP = 4'd12;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       f7;
    logic [1:0] result_src;
    logic       instr_done;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state;
  } outs_t;

  typedef struct packed {
    logic [3:0] ph;
    logic       rdy;
    logic [1:0] cause;
    logic       ack;
    logic [6:0] op;
    logic [2:0] f3;
    logic       zero;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  outs_t dut_v;
  assign dut_v = {bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write, bus.pc_write,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.ALUOp, bus.alu_f7_valid,
                  bus.result_src, bus.instr_done, bus.trap, bus.trap_cause, bus.state};

  int   checks = 0, errors = 0, idx = 0;
  int   done_cnt = 0, last_done = 0, mem_fetch = 0, mem_data = 0, pcw = 0, trap_cnt = 0;
  int   b_idx, b_done, b_mf, b_md, b_pcw, b_trap;
  cyc_t cyc_q[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_z;
  logic       ack_noise = 1'b0;

  // Expected outputs for one cycle, straight from the per-state output table.
  function automatic outs_t model(input cyc_t c);
    outs_t o;
    o = '0;
    o.state = c.ph;
    case (c.ph)
      P_FETCH:  begin o.mem_req = 1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
                      o.ir_write = c.rdy; o.pc_write = c.rdy; end
      P_DECODE: begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
      P_MEMADR: begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
      P_MEMRD:  begin o.mem_req = 1; o.i_or_d = 1; end
      P_MEMWB:  begin o.result_src = 2'b01; o.reg_write = 1; o.instr_done = 1; end
      P_MEMWR:  begin o.mem_req = 1; o.mem_we = 1; o.i_or_d = 1; o.instr_done = c.rdy; end
      P_EXEC_R: begin o.alu_src_a = 2'b01; o.alu_op = 2'b10; o.f7 = 1; end
      P_EXEC_I: begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; o.alu_op = 2'b10;
                      o.f7 = (c.f3 == 3'b101); end
      P_ALUWB:  begin o.reg_write = 1; o.instr_done = 1; end
      P_BRANCH: begin o.alu_src_a = 2'b01; o.alu_op = 2'b01; o.instr_done = 1;
                      o.pc_write = (c.f3 == 3'b000) ? c.zero : !c.zero; end
      P_JAL:    begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b10; o.pc_write = 1; end
      P_LUI:    begin o.result_src = 2'b11; o.reg_write = 1; o.instr_done = 1; end
      P_TRAP:   begin o.trap = 1; o.trap_cause = c.cause; end
      default:  ;
    endcase
    return o;
  endfunction

  task automatic push(input logic [3:0] ph, input logic rdy, input logic [1:0] cause,
                      input logic ack);
    cyc_t c;
    c.ph = ph; c.rdy = rdy; c.cause = cause; c.ack = ack;
    c.op = cur_op; c.f3 = cur_f3; c.zero = cur_z;
    cyc_q.push_back(c);
  endtask

  task automatic push_trap(input int hold, input logic [1:0] cause);
    for (int i = 0; i < hold; i++) push(P_TRAP, 1'b1, cause, 1'b0);
    push(P_TRAP, 1'b1, cause, 1'b1);
  endtask

  // Expand one instruction into its phase sequence; wf/wm are wait cycles in fetch/memory.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic z,
                       input int wf, input int wm, input int hold);
    cur_op = op; cur_f3 = f3; cur_z = z;
    for (int i = 0; i < wf; i++) push(P_FETCH, 1'b0, 2'b00, ack_noise);
    push(P_FETCH, 1'b1, 2'b00, ack_noise);
    push(P_DECODE, 1'b1, 2'b00, ack_noise);
    case (op)
      OP_LOAD: begin
        push(P_MEMADR, 1'b1, 2'b00, ack_noise);
        for (int i = 0; i < wm; i++) push(P_MEMRD, 1'b0, 2'b00, ack_noise);
        push(P_MEMRD, 1'b1, 2'b00, ack_noise);
        push(P_MEMWB, 1'b1, 2'b00, ack_noise);
      end
      OP_STORE: begin
        push(P_MEMADR, 1'b1, 2'b00, ack_noise);
        for (int i = 0; i < wm; i++) push(P_MEMWR, 1'b0, 2'b00, ack_noise);
        push(P_MEMWR, 1'b1, 2'b00, ack_noise);
      end
      OP_R:   begin push(P_EXEC_R, 1'b1, 2'b00, ack_noise); push(P_ALUWB, 1'b1, 2'b00, ack_noise); end
      OP_I:   begin push(P_EXEC_I, 1'b1, 2'b00, ack_noise); push(P_ALUWB, 1'b1, 2'b00, ack_noise); end
      OP_JAL: begin push(P_JAL, 1'b1, 2'b00, ack_noise); push(P_ALUWB, 1'b1, 2'b00, ack_noise); end
      OP_LUI: push(P_LUI, 1'b1, 2'b00, ack_noise);
      OP_BR: begin
        if (f3 == 3'b000 || f3 == 3'b001) push(P_BRANCH, 1'b1, 2'b00, ack_noise);
        else push_trap(hold, 2'b01);
      end
      default: push_trap(hold, 2'b01);
    endcase
  endtask

  task automatic play();
    cyc_t  c;
    outs_t e;
    while (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      bus.opcode = c.op; bus.funct3 = c.f3; bus.alu_zero = c.zero;
      bus.mem_ready = c.rdy; bus.trap_ack = c.ack;
      e = model(c);
      idx++;
      @(negedge clk);
      checks++;
      if (dut_v !== e) begin
        errors++;
        $display("FAIL cycle %0d phase %0d outputs got=%h exp=%h", idx, c.ph, dut_v, e);
      end
      if (bus.instr_done) begin done_cnt++; last_done = idx; end
      if (bus.mem_req && bus.i_or_d) mem_data++;
      if (bus.mem_req && !bus.i_or_d) mem_fetch++;
      if (bus.pc_write) pcw++;
      if (bus.trap) trap_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic snap();
    b_idx = idx; b_done = done_cnt; b_mf = mem_fetch; b_md = mem_data;
    b_pcw = pcw; b_trap = trap_cnt;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    bus.opcode = '0; bus.funct3 = '0; bus.alu_zero = 1'b0;
    bus.mem_ready = 1'b0; bus.trap_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    snap(); build(OP_I, 3'b000, 1'b0, 0, 0, 0); play();
    check("addi_done_cnt", done_cnt - b_done, 1);
    check("addi_done_cycle", last_done - b_idx, 4);

    cur_op = OP_LOAD; cur_f3 = 3'b010; cur_z = 1'b0;
    push(P_FETCH, 1'b1, 2'b00, 1'b0); push(P_DECODE, 1'b1, 2'b00, 1'b0);
    push(P_MEMADR, 1'b1, 2'b00, 1'b0);
    push(P_MEMRD, 1'b0, 2'b00, 1'b0); push(P_MEMRD, 1'b0, 2'b00, 1'b0);
    play();
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", int'(bus.state), 0);
    check("rst_mem_req", int'(bus.mem_req), 1);
    check("rst_reg_write", int'(bus.reg_write), 0);
    check("rst_trap", int'(bus.trap), 0);
    @(posedge clk); #1;

    snap(); build(OP_LOAD, 3'b010, 1'b0, 0, 3, 0); play();
    check("lw_done_cycle", last_done - b_idx, 8);
    check("lw_data_req_cycles", mem_data - b_md, 4);

    snap(); build(OP_STORE, 3'b010, 1'b0, 0, 0, 0); play();
    check("sw_done_cycle", last_done - b_idx, 4);

    snap(); build(OP_BR, 3'b000, 1'b1, 0, 0, 0); play();
    check("beq_taken_done_cycle", last_done - b_idx, 3);
    check("beq_taken_pc_writes", pcw - b_pcw, 2);
    snap(); build(OP_BR, 3'b001, 1'b1, 0, 0, 0); play();
    check("bne_zero_done_cycle", last_done - b_idx, 3);
    check("bne_zero_pc_writes", pcw - b_pcw, 1);
    snap(); build(OP_BR, 3'b001, 1'b0, 0, 0, 0); play();
    check("bne_taken_pc_writes", pcw - b_pcw, 2);

    ack_noise = 1'b1;
    snap(); build(OP_R, 3'b000, 1'b0, 0, 0, 0); play();
    check("r_done_cycle", last_done - b_idx, 4);
    check("r_stray_ack_no_trap", trap_cnt - b_trap, 0);
    ack_noise = 1'b0;
    snap(); build(OP_I, 3'b101, 1'b0, 0, 0, 0); play();
    check("srai_done_cycle", last_done - b_idx, 4);
    snap(); build(OP_JAL, 3'b000, 1'b0, 0, 0, 0); play();
    check("jal_done_cycle", last_done - b_idx, 4);
    snap(); build(OP_LUI, 3'b000, 1'b0, 0, 0, 0); play();
    check("lui_done_cycle", last_done - b_idx, 3);

    snap(); build(OP_BAD, 3'b000, 1'b0, 0, 0, 10); play();
    check("illegal_trap_cycles", trap_cnt - b_trap, 11);
    check("illegal_no_done", done_cnt - b_done, 0);
    snap(); build(OP_BR, 3'b100, 1'b0, 0, 0, 0); play();
    check("blt_trap_cycles", trap_cnt - b_trap, 1);

    snap();
    cur_op = OP_LUI; cur_f3 = 3'b000; cur_z = 1'b0;
    for (int i = 0; i < 16; i++) push(P_FETCH, 1'b0, 2'b00, 1'b0);
    push_trap(2, 2'b10);
    play();
    check("timeout_fetch_cycles", mem_fetch - b_mf, 16);
    check("timeout_trap_cycles", trap_cnt - b_trap, 3);

    snap(); build(OP_LUI, 3'b000, 1'b0, 15, 0, 0); play();
    check("late_ready_done_cycle", last_done - b_idx, 18);
    check("late_ready_no_trap", trap_cnt - b_trap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
